mem_stage_wbuf: RTL and testbench

MEM_STAGE_WBUF -- requirements
Module: mem_stage_wbuf

---
 rtl/mem_stage_wbuf_pkg.sv | 20 ++
 rtl/mem_stage_wbuf_fifo.sv | 54 +++++
 rtl/mem_stage_wbuf.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_wbuf.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_wbuf_pkg.sv
// Shared definitions for the memory stage: parameter defaults, front FSM
// state encodings and command decode helper.
package mem_stage_wbuf_pkg;

    localparam int AWIDTH_DEF     = 25;
    localparam int DWIDTH_DEF     = 32;
    localparam int WBUF_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 1023;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_REQ  = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    // Both or neither command bit set is an illegal request.
    function automatic logic cmd_illegal(input logic wr, input logic rd);
        return wr ~^ rd;
    endfunction

endpackage

// File: rtl/mem_stage_wbuf_fifo.sv
// Posted-write buffer: synchronous FIFO with registered occupancy count;
// the head entry is read combinationally from the storage array.
module wbuf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/mem_stage_wbuf.sv
// Memory stage with posted-write buffer: writes are acked on buffering and
// drained in the background; reads wait for the buffer to drain first.
module mem_stage_wbuf
    import mem_stage_wbuf_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                mem_req,
    input  logic                wr_mem,
    input  logic                rd_mem,
    input  logic [AWIDTH-1:0]   mem_addr,
    input  logic [DWIDTH-1:0]   mem_wr_data,
    input  logic [DWIDTH/8-1:0] mem_wr_strb,
    output logic                mem_ack,
    output logic                mem_err,
    output logic [DWIDTH-1:0]   mem_rd_data,
    output logic                wbuf_empty,
    output logic                wr_err,
    output logic                sdram_rd_req,
    output logic                sdram_wr_req,
    output logic [AWIDTH-1:0]   sdram_addr,
    output logic [DWIDTH-1:0]   sdram_wr_data,
    output logic [DWIDTH/8-1:0] sdram_wr_strb,
    input  logic [DWIDTH-1:0]   sdram_rd_data,
    input  logic                sdram_rd_ack,
    input  logic                sdram_wr_ack
);

    localparam int SW = DWIDTH / 8;
    localparam int EW = AWIDTH + DWIDTH + SW;
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0]   TO_LIM = TW'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_err;
    logic [DWIDTH-1:0] r_rd_data;
    logic              r_wr_act;
    logic              r_wr_err;
    logic [TW-1:0]     r_to_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic [AWIDTH-1:0] w_head_addr;
    logic [DWIDTH-1:0] w_head_data;
    logic [SW-1:0]     w_head_strb;
    logic              w_any_req;
    logic              w_any_ack;
    logic              w_to;

    assign {w_head_addr, w_head_data, w_head_strb} = w_head;

    assign w_push = (r_state == ST_IDLE) && mem_req && wr_mem && !rd_mem && !w_full;
    assign w_pop  = r_wr_act && (sdram_wr_ack || w_to);

    wbuf_fifo #(
        .WIDTH (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_din   ({mem_addr, mem_wr_data, mem_wr_strb}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Requests come only from registers or state decode, never from the acks.
    assign sdram_wr_req  = r_wr_act;
    assign sdram_rd_req  = (r_state == ST_RD_REQ);
    assign sdram_addr    = r_wr_act ? w_head_addr : mem_addr;
    assign sdram_wr_data = w_head_data;
    assign sdram_wr_strb = r_wr_act ? w_head_strb : '0;

    assign mem_ack     = (r_state == ST_ACK);
    assign mem_err     = r_err;
    assign mem_rd_data = r_rd_data;
    assign wbuf_empty  = w_empty;
    assign wr_err      = r_wr_err;

    assign w_any_req = sdram_rd_req | sdram_wr_req;
    assign w_any_ack = (sdram_rd_req & sdram_rd_ack) | (sdram_wr_req & sdram_wr_ack);
    assign w_to      = TO_EN && w_any_req && !w_any_ack && (r_to_cnt >= TO_LIM);

    // Every request is preceded by an idle cycle, so clearing on no-request
    // also restarts the count for each new request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to_cnt <= '0;
        end else if (w_any_req && !w_any_ack) begin
            if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_act <= 1'b0;
            r_wr_err <= 1'b0;
        end else if (r_wr_act) begin
            if (sdram_wr_ack || w_to) r_wr_act <= 1'b0;
            if (!sdram_wr_ack && w_to) r_wr_err <= 1'b1;
        end else if (!w_empty && (r_state != ST_RD_REQ)) begin
            r_wr_act <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req) begin
                        if (cmd_illegal(wr_mem, rd_mem)) begin
                            r_state <= ST_ACK;
                            r_err   <= 1'b1;
                        end else if (wr_mem) begin
                            if (!w_full) begin
                                r_state <= ST_ACK;
                                r_err   <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_empty && !r_wr_act) r_state <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (sdram_rd_ack) begin
                        r_rd_data <= sdram_rd_data;
                        r_err     <= 1'b0;
                        r_state   <= ST_ACK;
                    end else if (w_to) begin
                        r_rd_data <= '0;
                        r_err     <= 1'b1;
                        r_state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Directed bench for mem_stage_wbuf with an SDRAM responder model and
// queue-based scoreboards for SDRAM writes and requester reads.
module tb_mem_stage_wbuf;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          CLK;
    logic          RST;
    logic          mem_req, wr_mem, rd_mem;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [SW-1:0] mem_wr_strb;
    logic          mem_ack, mem_err;
    logic [DW-1:0] mem_rd_data;
    logic          wbuf_empty, wr_err;
    logic          sdram_rd_req, sdram_wr_req;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_wr_data;
    logic [SW-1:0] sdram_wr_strb;
    logic [DW-1:0] sdram_rd_data;
    logic          sdram_rd_ack, sdram_wr_ack;

    mem_stage_wbuf #(
        .AWIDTH     (AW),
        .DWIDTH     (DW),
        .WBUF_DEPTH (4),
        .TIMEOUT    (TO)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mem_req       (mem_req),
        .wr_mem        (wr_mem),
        .rd_mem        (rd_mem),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_strb   (mem_wr_strb),
        .mem_ack       (mem_ack),
        .mem_err       (mem_err),
        .mem_rd_data   (mem_rd_data),
        .wbuf_empty    (wbuf_empty),
        .wr_err        (wr_err),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_addr    (sdram_addr),
        .sdram_wr_data (sdram_wr_data),
        .sdram_wr_strb (sdram_wr_strb),
        .sdram_rd_data (sdram_rd_data),
        .sdram_rd_ack  (sdram_rd_ack),
        .sdram_wr_ack  (sdram_wr_ack)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  ack_dly  = 5;
    bit  wr_noack = 0;
    bit  rd_noack = 0;
    int  rd_rise_cyc    = -1;
    int  wack_first_cyc = -1;
    int  req_seen = 0;
    int  wr_acks  = 0;
    logic [DW-1:0] smem [0:255];
    wr_t           wq [$];
    logic [DW-1:0] rq_data [$];
    logic          rq_err [$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    // SDRAM responder: acks each request after ack_dly extra cycles.
    initial begin : sdram_model
        int  wcnt;
        int  rcnt;
        bit  rd_prev;
        wr_t e;
        wcnt = 0;
        rcnt = 0;
        rd_prev = 1'b0;
        sdram_wr_ack  = 1'b0;
        sdram_rd_ack  = 1'b0;
        sdram_rd_data = '0;
        for (int i = 0; i < 256; i++) smem[i] = '0;
        forever begin
            @(negedge CLK);
            sdram_wr_ack = 1'b0;
            sdram_rd_ack = 1'b0;
            if (sdram_wr_req || sdram_rd_req) begin
                req_seen++;
                check("req_exclusive", 64'(sdram_wr_req & sdram_rd_req), 64'd0);
            end
            if (sdram_rd_req && !rd_prev) begin
                rd_rise_cyc = cyc;
                check("raw_order_pending_writes", 64'(wq.size()), 64'd0);
            end
            rd_prev = sdram_rd_req;
            if (sdram_wr_req && !wr_noack) begin
                if (wcnt == ack_dly) begin
                    sdram_wr_ack = 1'b1;
                    wcnt = 0;
                    wr_acks++;
                    if (wack_first_cyc < 0) wack_first_cyc = cyc;
                    check("wr_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        check("wr_addr", 64'(sdram_addr), 64'(e.a));
                        check("wr_data", 64'(sdram_wr_data), 64'(e.d));
                        check("wr_strb", 64'(sdram_wr_strb), 64'(e.s));
                        smem[sdram_addr[7:0]] = merge(smem[sdram_addr[7:0]], sdram_wr_data, sdram_wr_strb);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            if (sdram_rd_req && !rd_noack) begin
                if (rcnt == ack_dly) begin
                    sdram_rd_ack  = 1'b1;
                    sdram_rd_data = smem[sdram_addr[7:0]];
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic wait_ack(input string tag, input int maxc, output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!mem_ack && lat < maxc);
        check({tag, "_ack_seen"}, 64'(mem_ack), 64'd1);
    endtask

    task automatic release_req();
        mem_req = 1'b0;
        wr_mem  = 1'b0;
        rd_mem  = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input int exp_lat, output int lat, output int ack_cyc);
        wr_t e;
        e.a = a; e.d = d; e.s = s;
        wq.push_back(e);
        mem_addr = a; mem_wr_data = d; mem_wr_strb = s;
        wr_mem = 1'b1; rd_mem = 1'b0; mem_req = 1'b1;
        wait_ack(tag, 60, lat);
        ack_cyc = cyc;
        if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(mem_err), 64'd0);
        release_req();
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input logic exp_e, output int ack_cyc);
        int lat;
        rq_data.push_back(exp_d);
        rq_err.push_back(exp_e);
        mem_addr = a;
        wr_mem = 1'b0; rd_mem = 1'b1; mem_req = 1'b1;
        wait_ack(tag, 200, lat);
        ack_cyc = cyc;
        check({tag, "_data"}, 64'(mem_rd_data), 64'(rq_data.pop_front()));
        check({tag, "_err"}, 64'(mem_err), 64'(rq_err.pop_front()));
        release_req();
    endtask

    task automatic cmd_err(input string tag, input logic w, input logic r);
        int lat;
        wr_mem = w; rd_mem = r; mem_addr = 25'h77; mem_req = 1'b1;
        wait_ack(tag, 20, lat);
        check({tag, "_latency"}, 64'(lat), 64'd1);
        check({tag, "_err"}, 64'(mem_err), 64'd1);
        release_req();
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while ((!wbuf_empty || sdram_wr_req) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_wbuf_empty"}, 64'(wbuf_empty), 64'd1);
        check({tag, "_wr_req_low"}, 64'(sdram_wr_req), 64'd0);
    endtask

    initial begin : stim
        int lat;
        int ac;
        int r0;
        int a0;
        RST = 1'b1;
        mem_req = 1'b0; wr_mem = 1'b0; rd_mem = 1'b0;
        mem_addr = '0; mem_wr_data = '0; mem_wr_strb = '0;
        repeat (3) @(negedge CLK);
        check("rst_mem_ack", 64'(mem_ack), 64'd0);
        check("rst_mem_err", 64'(mem_err), 64'd0);
        check("rst_rd_req", 64'(sdram_rd_req), 64'd0);
        check("rst_wr_req", 64'(sdram_wr_req), 64'd0);
        check("rst_wr_strb", 64'(sdram_wr_strb), 64'd0);
        check("rst_rd_data", 64'(mem_rd_data), 64'd0);
        check("rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Back-to-back posted writes, drained in order.
        ack_dly = 5;
        a0 = wr_acks;
        for (int i = 0; i < 4; i++)
            do_write("w_b2b", AW'(32'h10 + i), 32'hA5A5_0000 + i, 4'hF, 1, lat, ac);
        wait_drained("w_b2b");
        check("w_b2b_sdram_writes", 64'(wr_acks - a0), 64'd4);

        // Fifth write stalls on a full buffer until the first pop.
        ack_dly = 6;
        wack_first_cyc = -1;
        for (int i = 0; i < 4; i++)
            do_write("w_fill", AW'(32'h40 + i), 32'h0C0C_0000 + i, 4'hF, 1, lat, ac);
        do_write("w_full", 25'h44, 32'hF00D_0044, 4'hF, 0, lat, ac);
        check("w_full_stalled", 64'(lat > 1), 64'd1);
        check("w_full_accept_after_pop", 64'(ac - wack_first_cyc), 64'd2);
        wait_drained("w_full");

        // Read-after-write ordering and byte-strobe merge.
        ack_dly = 5;
        do_write("w_dead", 25'h20, 32'hDEAD_BEEF, 4'hF, 1, lat, ac);
        do_read("r_dead", 25'h20, 32'hDEAD_BEEF, 1'b0, ac);
        do_write("w_part", 25'h20, 32'h1122_3344, 4'b0101, 1, lat, ac);
        do_read("r_part", 25'h20, merge(32'hDEAD_BEEF, 32'h1122_3344, 4'b0101), 1'b0, ac);
        repeat (4) @(negedge CLK);
        check("rd_data_hold", 64'(mem_rd_data), 64'h0000_0000_DE22_BE44);

        // Read with no SDRAM ack times out.
        rd_noack = 1'b1;
        do_read("r_timeout", 25'h20, 32'h0, 1'b1, ac);
        check("r_timeout_cycles", 64'(ac - rd_rise_cyc), 64'd8);
        rd_noack = 1'b0;

        // Illegal commands: immediate error ack, no SDRAM traffic.
        r0 = req_seen;
        cmd_err("e_both", 1'b1, 1'b1);
        cmd_err("e_none", 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check("e_no_sdram_req", 64'(req_seen - r0), 64'd0);

        // Write timeout drops the head entry and latches wr_err.
        wr_noack = 1'b1;
        do_write("w_drop", 25'h50, 32'h5050_5050, 4'hF, 1, lat, ac);
        wait_drained("w_drop");
        check("w_drop_wr_err", 64'(wr_err), 64'd1);
        wq.delete();

        // Reset in the middle of a drain with three entries buffered.
        for (int i = 0; i < 3; i++)
            do_write("w_rst", AW'(32'h60 + i), 32'h6060_0000 + i, 4'hF, 1, lat, ac);
        check("pre_rst_wr_req", 64'(sdram_wr_req), 64'd1);
        check("pre_rst_not_empty", 64'(wbuf_empty), 64'd0);
        check("pre_rst_wr_err_sticky", 64'(wr_err), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_wr_req", 64'(sdram_wr_req), 64'd0);
        check("mid_rst_rd_req", 64'(sdram_rd_req), 64'd0);
        check("mid_rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
        check("mid_rst_wr_err", 64'(wr_err), 64'd0);
        check("mid_rst_mem_ack", 64'(mem_ack), 64'd0);
        RST = 1'b0;
        wr_noack = 1'b0;
        wq.delete();
        @(negedge CLK);

        // Normal traffic resumes after reset.
        do_write("w_post", 25'h70, 32'h1357_9BDF, 4'hF, 1, lat, ac);
        do_read("r_post", 25'h70, 32'h1357_9BDF, 1'b0, ac);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
